sobel_frame_ctrl: RTL and testbench

Frame sequencer for the 3x3 Sobel edge filter.
- Latches per-frame geometry and bypass config into shadow registers, then holds the filter in reset between frames.
- Gates the pixel-beat stream into the filter and counts filter output beats to detect frame completion.
- Reports done and error status to the host.
- Sits between the video source / register bank and the filter instance.

---
 rtl/sobel_pkg.sv | 23 ++
 rtl/sobel_beat_cnt.sv | 37 +++
 rtl/sobel_frame_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame sequencer.
package sobel_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitSof,
    StStream,
    StDrain,
    StDone
  } sobel_state_e;

  // Smallest frame the 3x3 kernel can process.
  localparam int unsigned MIN_ROWS      = 3;
  localparam int unsigned MIN_COL_BEATS = 2;

  typedef struct packed {
    logic sof;
    logic cfg;
    logic start;
  } sobel_err_t;

endpackage

// File: rtl/sobel_beat_cnt.sv
// Clearable beat counter that saturates at the expected frame length and flags,
// combinationally, when the count including this cycle's beat reaches it.
module sobel_beat_cnt
  import sobel_pkg::*;
#(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] exp_beats,
  output logic         reach
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != exp_beats)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign reach = (cnt_d == exp_beats);

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the 3x3 Sobel filter: config shadowing, stream gating, completion.
// Optional watchdog (err_wdog port, WDOG_CYC parameter): define SOBEL_FRAME_CTRL_WDOG_EN.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned PIXCNT  = 8,
  parameter int unsigned ROWS    = 2049,
  parameter int unsigned COLS    = 2448,
  parameter int unsigned GAP_CYC = 4,
  parameter int unsigned BEATW   = $clog2(ROWS * (COLS / PIXCNT) + 1)
`ifdef SOBEL_FRAME_CTRL_WDOG_EN
  ,
  parameter int unsigned WDOG_CYC = 65535
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [$clog2(ROWS)-1:0] cfg_rows,
  input  logic [$clog2(COLS)-1:0] cfg_cols,
  input  logic                    cfg_bypass,
  input  logic                    cfg_wr,
  input  logic                    start,
  input  logic                    in_sof,
  input  logic                    in_vld,
  output logic                    in_rdy,
  output logic [$clog2(ROWS)-1:0] filt_rows,
  output logic [$clog2(COLS)-1:0] filt_cols,
  output logic                    filt_bypass,
  output logic                    filt_new_frame,
  output logic                    filt_data_vld,
  input  logic                    filt_out_vld,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err_sof,
  output logic                    err_cfg,
  output logic                    err_start
`ifdef SOBEL_FRAME_CTRL_WDOG_EN
  ,
  output logic                    err_wdog
`endif
);

  localparam int unsigned RowW     = $clog2(ROWS);
  localparam int unsigned ColW     = $clog2(COLS);
  localparam int unsigned PixShift = $clog2(PIXCNT);
  localparam int unsigned GapW     = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [ColW-1:0] ColMask = ColW'(PIXCNT - 1);

  sobel_state_e     state_q, state_d;
  logic [RowW-1:0]  shd_rows_q, act_rows_q;
  logic [ColW-1:0]  shd_cols_q, act_cols_q;
  logic             shd_bypass_q, act_bypass_q;
  logic [BEATW-1:0] exp_q;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             pending_q, pending_d;
  sobel_err_t       err_q, err_d;

  logic [ColW-1:0]  shd_col_beats;
  logic             geom_ok, start_ok, arm_entry;
  logic             in_reach, out_reach, cnt_clr, out_en, busy_slot;

`ifdef SOBEL_FRAME_CTRL_WDOG_EN
  localparam int unsigned WdW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_wdog_q, err_wdog_d;
`endif

  // Geometry check always uses the shadow copy that ARM would latch.
  assign shd_col_beats = shd_cols_q >> PixShift;
  assign geom_ok  = (shd_rows_q >= RowW'(MIN_ROWS)) &&
                    (shd_col_beats >= ColW'(MIN_COL_BEATS)) &&
                    ((shd_cols_q & ColMask) == '0);
  assign start_ok = start & geom_ok;

  assign in_rdy         = (state_q == StWaitSof) || (state_q == StStream);
  // Pre-SOF beats are consumed but not forwarded.
  assign filt_data_vld  = in_vld & in_rdy & ((state_q == StStream) | in_sof);
  assign filt_new_frame = (state_q == StArm);
  assign busy           = (state_q != StIdle);
  assign frame_done     = (state_q == StDone);
  assign filt_rows      = act_rows_q;
  assign filt_cols      = act_cols_q;
  assign filt_bypass    = act_bypass_q;
  assign err_sof        = err_q.sof;
  assign err_cfg        = err_q.cfg;
  assign err_start      = err_q.start;

  assign cnt_clr   = (state_q == StArm);
  assign out_en    = filt_out_vld && ((state_q == StStream) || (state_q == StDrain));
  assign busy_slot = (state_q != StIdle) && (state_q != StDone);

  sobel_beat_cnt #(
    .W (BEATW)
  ) u_in_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .en        (filt_data_vld),
    .exp_beats (exp_q),
    .reach     (in_reach)
  );

  sobel_beat_cnt #(
    .W (BEATW)
  ) u_out_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .en        (out_en),
    .exp_beats (exp_q),
    .reach     (out_reach)
  );

  always_comb begin
    state_d   = state_q;
    gap_d     = '0;
    pending_d = pending_q;
    err_d     = err_q;
    arm_entry = 1'b0;

    if (start && !geom_ok) begin
      err_d.cfg = 1'b1;
    end else if (start_ok && busy_slot) begin
      if (pending_q) begin
        err_d.start = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    if ((state_q == StStream) && in_vld && in_sof) begin
      err_d.sof = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StArm;
      end
      StArm: begin
        if (gap_q == GapW'(GAP_CYC - 1)) begin
          state_d = StWaitSof;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      StWaitSof: begin
        if (filt_data_vld) state_d = StStream;
      end
      StStream: begin
        if (in_reach) state_d = StDrain;
      end
      StDrain: begin
        if (out_reach) state_d = StDone;
      end
      StDone: begin
        // A start arriving here either re-arms directly or refills the slot just consumed.
        state_d   = (pending_q || start_ok) ? StArm : StIdle;
        pending_d = pending_q && start_ok;
      end
      default: state_d = StIdle;
    endcase

`ifdef SOBEL_FRAME_CTRL_WDOG_EN
    wd_d       = '0;
    err_wdog_d = err_wdog_q;
    if (((state_q == StWaitSof) || (state_q == StStream) || (state_q == StDrain)) &&
        !(in_vld && in_rdy) && !filt_out_vld) begin
      if (wd_q == WdW'(WDOG_CYC - 1)) begin
        err_wdog_d = 1'b1;
        state_d    = StIdle;
        pending_d  = 1'b0;
      end else begin
        wd_d = wd_q + WdW'(1);
      end
    end
`endif

    arm_entry = (state_d == StArm) && (state_q != StArm);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      gap_q        <= '0;
      pending_q    <= 1'b0;
      err_q        <= '0;
      shd_rows_q   <= '0;
      shd_cols_q   <= '0;
      shd_bypass_q <= 1'b0;
      act_rows_q   <= '0;
      act_cols_q   <= '0;
      act_bypass_q <= 1'b0;
      exp_q        <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      if (cfg_wr) begin
        shd_rows_q   <= cfg_rows;
        shd_cols_q   <= cfg_cols;
        shd_bypass_q <= cfg_bypass;
      end
      if (arm_entry) begin
        act_rows_q   <= shd_rows_q;
        act_cols_q   <= shd_cols_q;
        act_bypass_q <= shd_bypass_q;
        exp_q        <= BEATW'(shd_rows_q) * BEATW'(shd_col_beats);
      end
    end
  end

`ifdef SOBEL_FRAME_CTRL_WDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q       <= '0;
      err_wdog_q <= 1'b0;
    end else begin
      wd_q       <= wd_d;
      err_wdog_q <= err_wdog_d;
    end
  end

  assign err_wdog = err_wdog_q;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl: directed frames plus randomized traffic,
// all outputs compared every cycle against a frame-level behavioural model.
module tb_sobel_frame_ctrl;

  localparam int PIXCNT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] cfg_rows = '0;
  logic [11:0] cfg_cols = '0;
  logic        cfg_bypass = 1'b0;
  logic        cfg_wr = 1'b0;
  logic        start = 1'b0;
  logic        in_sof = 1'b0;
  logic        in_vld = 1'b0;
  logic        filt_out_vld = 1'b0;
  logic        in_rdy, filt_bypass, filt_new_frame, filt_data_vld;
  logic        busy, frame_done, err_sof, err_cfg, err_start;
  logic [11:0] filt_rows, filt_cols;

  sobel_frame_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_rows       (cfg_rows),
    .cfg_cols       (cfg_cols),
    .cfg_bypass     (cfg_bypass),
    .cfg_wr         (cfg_wr),
    .start          (start),
    .in_sof         (in_sof),
    .in_vld         (in_vld),
    .in_rdy         (in_rdy),
    .filt_rows      (filt_rows),
    .filt_cols      (filt_cols),
    .filt_bypass    (filt_bypass),
    .filt_new_frame (filt_new_frame),
    .filt_data_vld  (filt_data_vld),
    .filt_out_vld   (filt_out_vld),
    .busy           (busy),
    .frame_done     (frame_done),
    .err_sof        (err_sof),
    .err_cfg        (err_cfg),
    .err_start      (err_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model: where the frame is, how many beats in/out, and what is latched.
  localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_STREAM = 3, P_DRAIN = 4, P_DONE = 5;
  int m_phase, m_gap, m_in, m_out, m_exp;
  int s_rows, s_cols, a_rows, a_cols;
  bit s_byp, a_byp, m_pend, e_sof, e_cfg, e_start;
  int nf_cnt = 0, dv_cnt = 0, fd_cnt = 0;

  task automatic model_reset();
    m_phase = P_IDLE; m_gap = 0; m_in = 0; m_out = 0; m_exp = 0; m_pend = 0;
    s_rows = 0; s_cols = 0; s_byp = 0; a_rows = 0; a_cols = 0; a_byp = 0;
    e_sof = 0; e_cfg = 0; e_start = 0;
  endtask

  task automatic model_arm();
    m_phase = P_ARM; m_gap = 0; m_in = 0; m_out = 0;
    a_rows = s_rows; a_cols = s_cols; a_byp = s_byp;
    m_exp = s_rows * (s_cols / PIXCNT);
  endtask

  task automatic model_step();
    bit ok, sok;
    ok  = (s_rows >= 3) && ((s_cols / PIXCNT) >= 2) && ((s_cols % PIXCNT) == 0);
    sok = start && ok;
    if (start && !ok) e_cfg = 1;
    if (sok && m_phase != P_IDLE && m_phase != P_DONE) begin
      if (m_pend) e_start = 1;
      else m_pend = 1;
    end
    case (m_phase)
      P_IDLE: if (sok) model_arm();
      P_ARM: begin
        m_gap++;
        if (m_gap == 4) m_phase = P_WAIT;
      end
      P_WAIT: if (in_vld && in_sof) begin
        m_in = 1;
        m_phase = P_STREAM;
      end
      P_STREAM: begin
        if (filt_out_vld && m_out < m_exp) m_out++;
        if (in_vld) begin
          m_in++;
          if (in_sof) e_sof = 1;
        end
        if (m_in == m_exp) m_phase = P_DRAIN;
      end
      P_DRAIN: begin
        if (filt_out_vld && m_out < m_exp) m_out++;
        if (m_out == m_exp) m_phase = P_DONE;
      end
      default: begin
        if (m_pend || sok) begin
          m_pend = m_pend && sok;
          model_arm();
        end else begin
          m_phase = P_IDLE;
        end
      end
    endcase
    if (cfg_wr) begin
      s_rows = int'(cfg_rows); s_cols = int'(cfg_cols); s_byp = cfg_bypass;
    end
  endtask

  // Compare process: inputs change at negedge, outputs checked 2 time units later.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      if (reset) model_reset();
      check("in_rdy", in_rdy, (m_phase == P_WAIT || m_phase == P_STREAM));
      check("filt_data_vld", filt_data_vld,
            (m_phase == P_WAIT && in_vld && in_sof) || (m_phase == P_STREAM && in_vld));
      check("filt_new_frame", filt_new_frame, m_phase == P_ARM);
      check("busy", busy, m_phase != P_IDLE);
      check("frame_done", frame_done, m_phase == P_DONE);
      check("filt_rows", filt_rows, a_rows);
      check("filt_cols", filt_cols, a_cols);
      check("filt_bypass", filt_bypass, a_byp);
      check("err_sof", err_sof, e_sof);
      check("err_cfg", err_cfg, e_cfg);
      check("err_start", err_start, e_start);
      nf_cnt += int'(filt_new_frame);
      dv_cnt += int'(filt_data_vld);
      fd_cnt += int'(frame_done);
      if (!reset) model_step();
    end
  end

  task automatic tick(input bit v, input bit s, input bit ov, input bit st);
    @(negedge clk);
    in_vld = v; in_sof = s; filt_out_vld = ov; start = st; cfg_wr = 0;
  endtask

  task automatic wr_cfg(input int r, input int c, input bit b);
    @(negedge clk);
    cfg_rows = 12'(r); cfg_cols = 12'(c); cfg_bypass = b; cfg_wr = 1;
    in_vld = 0; in_sof = 0; filt_out_vld = 0; start = 0;
  endtask

  task automatic arm_frame();
    tick(0, 0, 0, 1);
    repeat (4) tick(0, 0, 0, 0);
  endtask

  task automatic frame_in(input int n);
    tick(1, 1, 0, 0);
    repeat (n - 1) tick(1, 0, 0, 0);
  endtask

  task automatic frame_out(input int n);
    repeat (n) tick(0, 0, 1, 0);
  endtask

  int nf0, dv0, fd0;
  int col_pick[5] = '{8, 16, 20, 24, 32};

  initial begin
    repeat (3) @(negedge clk);
    #3;
    check("rst_busy", busy, 0);
    check("rst_new_frame", filt_new_frame, 0);
    @(negedge clk);
    reset = 0;

    // Basic 4x16 frame.
    wr_cfg(4, 16, 1);
    nf0 = nf_cnt; dv0 = dv_cnt; fd0 = fd_cnt;
    arm_frame();
    frame_in(8);
    tick(1, 0, 0, 0);
    #3;
    check("t1_rdy_after_last", in_rdy, 0);
    check("t1_new_frame_cycles", nf_cnt - nf0, 4);
    check("t1_fwd_beats", dv_cnt - dv0, 8);
    check("t1_model_exp", m_exp, 8);
    check("t1_rows", filt_rows, 4);
    frame_out(8);
    tick(0, 0, 0, 0);
    #3;
    check("t1_done_pulse", frame_done, 1);
    tick(0, 0, 0, 0);
    #3;
    check("t1_idle_after", busy, 0);
    check("t1_done_count", fd_cnt - fd0, 1);

    // Misaligned columns rejected, then a good frame.
    wr_cfg(4, 20, 0);
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    #3;
    check("t2_err_cfg", err_cfg, 1);
    check("t2_busy", busy, 0);
    wr_cfg(4, 16, 0);
    fd0 = fd_cnt;
    arm_frame();
    frame_in(8);
    frame_out(8);
    repeat (2) tick(0, 0, 0, 0);
    check("t2_done_count", fd_cnt - fd0, 1);

    // Pending start in STREAM, dropped start in DRAIN, mid-frame config change.
    arm_frame();
    tick(1, 1, 0, 0);
    tick(1, 0, 0, 1);
    wr_cfg(6, 16, 0);
    repeat (6) tick(1, 0, 0, 0);
    #3;
    check("t3_rows_stable", filt_rows, 4);
    tick(0, 0, 1, 1);
    frame_out(7);
    tick(0, 0, 0, 0);
    #3;
    check("t3_done", frame_done, 1);
    check("t3_err_start", err_start, 1);
    tick(0, 0, 0, 0);
    #3;
    check("t3_rearm", filt_new_frame, 1);
    check("t3_new_rows", filt_rows, 6);
    check("t3_model_exp", m_exp, 12);
    repeat (3) tick(0, 0, 0, 0);
    frame_in(12);
    frame_out(12);
    repeat (2) tick(0, 0, 0, 0);
    #3;
    check("t3_idle", busy, 0);

    // Reset while draining, then a full frame.
    wr_cfg(4, 16, 0);
    arm_frame();
    frame_in(8);
    tick(0, 0, 1, 0);
    @(negedge clk);
    reset = 1; in_vld = 0; filt_out_vld = 0;
    #3;
    check("t6_busy", busy, 0);
    check("t6_rows", filt_rows, 0);
    check("t6_err_start", err_start, 0);
    @(negedge clk);
    reset = 0;
    wr_cfg(4, 16, 0);
    fd0 = fd_cnt;
    arm_frame();
    frame_in(8);
    frame_out(8);
    repeat (2) tick(0, 0, 0, 0);
    check("t6_done_count", fd_cnt - fd0, 1);

    // Pre-SOF beats discarded, second SOF flagged.
    dv0 = dv_cnt;
    arm_frame();
    repeat (3) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    repeat (3) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    repeat (3) tick(1, 0, 0, 0);
    #3;
    check("t5_err_sof", err_sof, 1);
    check("t5_fwd_beats", dv_cnt - dv0, 8);
    frame_out(8);
    repeat (2) tick(0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      reset  = ($urandom_range(0, 1999) == 0);
      cfg_wr = ($urandom_range(0, 39) == 0);
      if (cfg_wr) begin
        cfg_rows   = 12'($urandom_range(2, 6));
        cfg_cols   = 12'(col_pick[$urandom_range(0, 4)]);
        cfg_bypass = 1'($urandom_range(0, 1));
      end
      start        = ($urandom_range(0, 29) == 0);
      in_vld       = ($urandom_range(0, 3) != 0);
      in_sof       = in_vld && ($urandom_range(0, 7) == 0);
      filt_out_vld = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    reset = 0; start = 0; cfg_wr = 0; in_vld = 0; filt_out_vld = 0;
    repeat (2) @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
